// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the memory-bus responder: FSM state encoding and default widths.
package mem_bus_responder_pkg;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_DONE = 2'd3
  } resp_state_e;

endpackage

// File: rtl/mem_bus_responder_ram.sv
// mem_bus_ram: single-port storage with synchronous write and registered read.
// The storage array itself is never reset; only the read register is.
module mem_bus_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  // storage write port
  always_ff @(posedge i_clk) begin
    if (i_en && i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // read register holds its value across writes and idle cycles
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_en && !i_we) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_bus_responder.sv
// Asynchronous-style memory bus responder with optional wait states.
// Define MEM_BUS_RESP_WAIT_EN to include the WAIT state and wait-state counter.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              AS_N,
  input  logic              WR_N,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DIN,
  output logic              ACK_N,
  output logic [DATA_W-1:0] DOUT,
  output logic [1:0]        RESP_STATE
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
`ifdef MEM_BUS_RESP_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  resp_state_e       r_state;
  resp_state_e       w_next;
  logic              r_ack_n;
  logic              w_access;
  logic              w_sel_wr_n;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_din;

`ifdef MEM_BUS_RESP_WAIT_EN
  logic [3:0]        r_cnt;
  logic              r_wr_n;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;

  // wait-state counter, loaded on capture
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt <= 4'd0;
    end else if (r_state == ST_IDLE && !AS_N) begin
      r_cnt <= WAIT_INIT;
    end else if (r_state == ST_WAIT) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // request capture; later bus changes are ignored
  always_ff @(posedge CLK) begin
    if (!RESET && r_state == ST_IDLE && !AS_N) begin
      r_wr_n <= WR_N;
      r_addr <= ADDR;
      r_din  <= DIN;
    end
  end

  // a zero-wait access happens on the capture edge, so it must use the live bus
  assign w_sel_wr_n = (r_state == ST_IDLE) ? WR_N : r_wr_n;
  assign w_sel_addr = (r_state == ST_IDLE) ? ADDR : r_addr;
  assign w_sel_din  = (r_state == ST_IDLE) ? DIN  : r_din;
`else
  assign w_sel_wr_n = WR_N;
  assign w_sel_addr = ADDR;
  assign w_sel_din  = DIN;
`endif

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!AS_N) begin
          w_next = (WAIT_EN && WAIT_INIT != 4'd0) ? ST_WAIT : ST_ACK;
        end else begin
          w_next = ST_IDLE;
        end
      end
`ifdef MEM_BUS_RESP_WAIT_EN
      ST_WAIT: begin
        if (AS_N) begin
          w_next = ST_IDLE;
        end else if (r_cnt == 4'd1) begin
          w_next = ST_ACK;
        end else begin
          w_next = ST_WAIT;
        end
      end
`endif
      ST_ACK:  w_next = ST_DONE;
      ST_DONE: begin
        if (AS_N) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_DONE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // memory is touched only on the edge that enters ACK
  assign w_access = !RESET && (w_next == ST_ACK);

  // state register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // acknowledge is the registered image of the ACK state: one cycle low
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_ack_n <= 1'b1;
    end else begin
      r_ack_n <= (r_state != ST_ACK);
    end
  end

  mem_bus_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_en    (w_access),
    .i_we    (!w_sel_wr_n),
    .i_addr  (w_sel_addr),
    .i_wdata (w_sel_din),
    .o_rdata (DOUT)
  );

  assign ACK_N      = r_ack_n;
  assign RESP_STATE = r_state;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: directed accesses push expectations,
// a negedge monitor pops and checks them whenever ACK_N is low.
module tb_mem_bus_responder;

  localparam int WC = 2;
`ifdef MEM_BUS_RESP_WAIT_EN
  localparam int LAT = WC + 1;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int          cyc;
    logic [31:0] dout;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        AS_N = 1'b1;
  logic        WR_N = 1'b1;
  logic [7:0]  ADDR = 8'h00;
  logic [31:0] DIN = 32'h0;
  logic        ACK_N;
  logic [31:0] DOUT;
  logic [1:0]  RESP_STATE;

  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_rd = 32'h0;
  logic [31:0] model [0:255];
  exp_t        q[$];

  mem_bus_responder #(
    .ADDR_W      (8),
    .DATA_W      (32),
    .WAIT_CYCLES (WC)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .AS_N       (AS_N),
    .WR_N       (WR_N),
    .ADDR       (ADDR),
    .DIN        (DIN),
    .ACK_N      (ACK_N),
    .DOUT       (DOUT),
    .RESP_STATE (RESP_STATE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every low ACK_N cycle must match a queued expectation
  always @(negedge CLK) begin
    if (ACK_N === 1'b0) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ack: ACK_N low at cycle %0d with nothing expected", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("ack_cycle", 32'(cyc), 32'(e.cyc));
        check("dout_at_ack", DOUT, e.dout);
      end
    end
  end

  task automatic access(input logic wr_n, input logic [7:0] a, input logic [31:0] d, input int hold);
    int   k;
    bit   seen;
    exp_t e;
    @(negedge CLK);
    AS_N = 1'b0;
    WR_N = wr_n;
    ADDR = a;
    DIN  = d;
    k = cyc + 1;
    if (!wr_n) begin
      model[a] = d;
    end else begin
      last_rd = model[a];
    end
    e.cyc  = k + LAT;
    e.dout = last_rd;
    q.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (i == 0) begin
        ADDR = ~a;
        DIN  = ~d;
        WR_N = ~wr_n;
      end
      if (ACK_N === 1'b0) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: no ACK_N for access to %h", a);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      check("done_hold_state", 32'(RESP_STATE), 32'd3);
      check("done_hold_ack_n", 32'(ACK_N), 32'd1);
    end
    AS_N = 1'b1;
    WR_N = 1'b1;
    @(negedge CLK);
    check("idle_after_access", 32'(RESP_STATE), 32'd0);
  endtask

  initial begin
    // reset overrides an active strobe
    AS_N = 1'b0;
    WR_N = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_ack_n", 32'(ACK_N), 32'd1);
    check("reset_dout", DOUT, 32'h0);
    check("reset_state", 32'(RESP_STATE), 32'd0);
    RESET = 1'b0;
    AS_N  = 1'b1;
    WR_N  = 1'b1;
    @(negedge CLK);

    access(1'b0, 8'h05, 32'hDEADBEEF, 0);
    access(1'b1, 8'h05, 32'h0, 0);

    access(1'b0, 8'h10, 32'h0000_1111, 0);
`ifdef MEM_BUS_RESP_WAIT_EN
    @(negedge CLK);
    AS_N = 1'b0;
    WR_N = 1'b0;
    ADDR = 8'h10;
    DIN  = 32'h0000_1234;
    @(negedge CLK);
    check("abort_in_wait", 32'(RESP_STATE), 32'd1);
    AS_N = 1'b1;
    WR_N = 1'b1;
    repeat (4) @(negedge CLK);
    check("abort_idle", 32'(RESP_STATE), 32'd0);
`endif
    access(1'b1, 8'h10, 32'h0, 0);

    access(1'b1, 8'h05, 32'h0, 4);

    access(1'b0, 8'h20, 32'h0000_2020, 0);
    @(negedge CLK);
    AS_N = 1'b0;
    WR_N = 1'b0;
    ADDR = 8'h20;
    DIN  = 32'h0BAD_0BAD;
`ifdef MEM_BUS_RESP_WAIT_EN
    @(negedge CLK);
    check("pre_reset_wait", 32'(RESP_STATE), 32'd1);
    RESET = 1'b1;
`else
    RESET = 1'b1;
`endif
    @(negedge CLK);
    check("midreset_ack_n", 32'(ACK_N), 32'd1);
    check("midreset_dout", DOUT, 32'h0);
    check("midreset_state", 32'(RESP_STATE), 32'd0);
    RESET = 1'b0;
    AS_N  = 1'b1;
    WR_N  = 1'b1;
    last_rd = 32'h0;
    access(1'b1, 8'h20, 32'h0, 0);

    access(1'b1, 8'h05, 32'h0, 0);
    access(1'b0, 8'hFF, 32'hA5A5A5A5, 0);
    access(1'b1, 8'hFF, 32'h0, 0);

    repeat (4) @(negedge CLK);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
